// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline types: stall vector default width, reset polarity and the
// per-cycle action a stage register can take.
package project_types;

    localparam int   STALL_W_DEFAULT = 6;
    localparam logic RST_ENABLE      = 1'b1;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_ADVANCE
    } stage_action_t;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter: counts enabled cycles, sticks at all-ones, and only
// a synchronous reset clears it.
module sat_counter
    import project_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (enable && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline register between stage STAGE and STAGE+1: carries payload,
// valid and delay-slot flags, and honours stall/flush with bubble/hold counters.
module pipe_stage_reg
    import project_types::*;
#(
    parameter int DATA_W  = 128,
    parameter int STALL_W = STALL_W_DEFAULT,
    parameter int STAGE   = 2,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_payload,
    input  logic               in_delayslot,
    input  logic               in_next_delayslot,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_payload,
    output logic               out_delayslot,
    output logic               fb_in_delayslot,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt
);

    if ((STAGE < 0) || (STAGE > STALL_W - 2)) begin : g_bad_stage
        $error("pipe_stage_reg: STAGE must lie in 0..STALL_W-2");
    end

    logic su;
    logic sd;
    // Only our two stall bits matter; the rest are folded into a sink.
    logic unused_stall_bits;

    assign su                = stall[STAGE];
    assign sd                = stall[STAGE+1];
    assign unused_stall_bits = ^stall;

    stage_action_t action;

    always_comb begin
        action = ACT_ADVANCE;
        if (rst == RST_ENABLE) begin
            action = ACT_RESET;
        end else if (flush) begin
            action = ACT_FLUSH;
        end else if (sd) begin
            // Downstream stalled: hold, even for the illegal su=0, sd=1 pattern.
            action = ACT_HOLD;
        end else if (su) begin
            action = ACT_BUBBLE;
        end
    end

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] payload_q, payload_d;
    logic              ds_q,      ds_d;
    logic              fb_q,      fb_d;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        ds_d      = ds_q;
        fb_d      = fb_q;
        case (action)
            ACT_RESET, ACT_FLUSH: begin
                valid_d   = 1'b0;
                payload_d = '0;
                ds_d      = 1'b0;
                fb_d      = 1'b0;
            end
            ACT_BUBBLE: begin
                // The branch is still upstream, so its delay-slot feedback stays.
                valid_d   = 1'b0;
                payload_d = '0;
                ds_d      = 1'b0;
            end
            ACT_HOLD: begin
            end
            ACT_ADVANCE: begin
                valid_d   = in_valid;
                payload_d = in_payload;
                ds_d      = in_delayslot;
                fb_d      = in_next_delayslot;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
            ds_q      <= 1'b0;
            fb_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            ds_q      <= ds_d;
            fb_q      <= fb_d;
        end
    end

    assign out_valid       = valid_q;
    assign out_payload     = payload_q;
    assign out_delayslot   = ds_q;
    assign fb_in_delayslot = fb_q;

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (action == ACT_BUBBLE),
        .cnt    (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clk    (clk),
        .rst    (rst),
        .enable (action == ACT_HOLD),
        .cnt    (hold_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a randomized
// run against a rule-level reference model; a CNT_W=4 copy shares all inputs.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_payload;
    logic         in_delayslot;
    logic         in_next_delayslot;

    logic         out_valid, out_delayslot, fb_in_delayslot;
    logic [127:0] out_payload;
    logic [15:0]  bubble_cnt, hold_cnt;

    logic         s_valid, s_delayslot, s_fb;
    logic [127:0] s_payload;
    logic [3:0]   s_bubble, s_hold;

    int n_checks = 0;
    int n_fail   = 0;
    bit allow_illegal = 1'b0;

    // Reference state
    logic         m_valid, m_ds, m_fb;
    logic [127:0] m_payload;
    int           m_bub, m_hold;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(128), .STALL_W(6), .STAGE(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_delayslot(in_delayslot), .in_next_delayslot(in_next_delayslot),
        .out_valid(out_valid), .out_payload(out_payload),
        .out_delayslot(out_delayslot), .fb_in_delayslot(fb_in_delayslot),
        .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
    );

    pipe_stage_reg #(.DATA_W(128), .STALL_W(6), .STAGE(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_payload(in_payload),
        .in_delayslot(in_delayslot), .in_next_delayslot(in_next_delayslot),
        .out_valid(s_valid), .out_payload(s_payload),
        .out_delayslot(s_delayslot), .fb_in_delayslot(s_fb),
        .bubble_cnt(s_bubble), .hold_cnt(s_hold)
    );

    // The stall controller must never stall downstream while upstream runs.
    always @(posedge clk) begin
        if (!rst && !allow_illegal) begin
            assert (!(stall[3] && !stall[2])) else $error("illegal stall pattern su=0 sd=1");
        end
    end

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic logic [170:0] model_vec();
        return {m_valid, m_ds, m_fb, m_payload,
                16'(sat(m_bub, 16)), 16'(sat(m_hold, 16)),
                4'(sat(m_bub, 4)), 4'(sat(m_hold, 4))};
    endfunction

    function automatic logic [170:0] dut_vec();
        return {out_valid, out_delayslot, fb_in_delayslot, out_payload,
                bubble_cnt, hold_cnt, s_bubble, s_hold};
    endfunction

    // Clock edge, then apply the behavioural rules to the inputs that edge saw.
    task automatic tick();
        logic su, sd;
        @(posedge clk);
        #1;
        su = stall[2];
        sd = stall[3];
        if (rst) begin
            {m_valid, m_ds, m_fb, m_payload} = '0;
            m_bub  = 0;
            m_hold = 0;
        end else if (flush) begin
            {m_valid, m_ds, m_fb, m_payload} = '0;
        end else if (sd) begin
            m_hold++;
        end else if (su) begin
            {m_valid, m_ds, m_payload} = '0;
            m_bub++;
        end else begin
            m_valid   = in_valid;
            m_ds      = in_delayslot;
            m_fb      = in_next_delayslot;
            m_payload = in_payload;
        end
    endtask

    task automatic drive(input logic [5:0] st, input logic v, input logic [127:0] p,
                         input logic ds, input logic nds);
        stall             = st;
        in_valid          = v;
        in_payload        = p;
        in_delayslot      = ds;
        in_next_delayslot = nds;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        flush = 1'b0;
        drive(6'b0, 1'b1, '1, 1'b1, 1'b1);
        tick();
        tick();
        n_checks++;
        if ({out_valid, out_delayslot, fb_in_delayslot, out_payload, bubble_cnt, hold_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset: got v=%b ds=%b fb=%b pay=%h bub=%0d hold=%0d, want all 0",
                     out_valid, out_delayslot, fb_in_delayslot, out_payload, bubble_cnt, hold_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_advance();
        drive(6'b0, 1'b1, 128'hA5, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, out_delayslot, fb_in_delayslot, out_payload} !== {3'b111, 128'hA5}) begin
            n_fail++;
            $display("FAIL advance: got v=%b ds=%b fb=%b pay=%h, want 1 1 1 a5",
                     out_valid, out_delayslot, fb_in_delayslot, out_payload);
        end
    endtask

    task automatic test_bubble();
        drive(6'b0, 1'b1, 128'h11, 1'b0, 1'b1);
        tick();
        drive(6'b000111, 1'b1, 128'h99, 1'b1, 1'b0);
        tick();
        n_checks++;
        if ({out_valid, out_payload, fb_in_delayslot} !== {1'b0, 128'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL bubble_first: got v=%b pay=%h fb=%b, want 0 0 1",
                     out_valid, out_payload, fb_in_delayslot);
        end
        tick();
        tick();
        n_checks++;
        if (bubble_cnt !== 16'd3 || fb_in_delayslot !== 1'b1) begin
            n_fail++;
            $display("FAIL bubble_count: got bub=%0d fb=%b, want 3 1", bubble_cnt, fb_in_delayslot);
        end
    endtask

    task automatic test_hold();
        drive(6'b0, 1'b1, 128'h22, 1'b0, 1'b0);
        tick();
        drive(6'b001111, 1'b1, 128'h33, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (out_payload !== 128'h22 || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got pay=%h v=%b, want 22 1", i, out_payload, out_valid);
            end
        end
        n_checks++;
        if (hold_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL hold_count: got %0d, want 4", hold_cnt);
        end
        stall = 6'b0;
        tick();
        n_checks++;
        if (out_payload !== 128'h33) begin
            n_fail++;
            $display("FAIL hold_release: got %h, want 33", out_payload);
        end
    endtask

    task automatic test_flush();
        drive(6'b001111, 1'b1, 128'h44, 1'b1, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++;
        if ({out_valid, out_delayslot, fb_in_delayslot, out_payload} !== '0 || hold_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL flush: got v=%b ds=%b fb=%b pay=%h hold=%0d, want 0 0 0 0 4",
                     out_valid, out_delayslot, fb_in_delayslot, out_payload, hold_cnt);
        end
    endtask

    task automatic test_illegal_and_ignored();
        drive(6'b0, 1'b1, 128'h44, 1'b0, 1'b1);
        tick();
        allow_illegal = 1'b1;
        drive(6'b001000, 1'b1, 128'h55, 1'b0, 1'b0);
        tick();
        allow_illegal = 1'b0;
        n_checks++;
        if (out_payload !== 128'h44 || fb_in_delayslot !== 1'b1 || hold_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL illegal_hold: got pay=%h fb=%b hold=%0d, want 44 1 5",
                     out_payload, fb_in_delayslot, hold_cnt);
        end
        drive(6'b110011, 1'b0, 128'h66, 1'b1, 1'b0);
        tick();
        n_checks++;
        if (dut_vec() !== model_vec() || out_payload !== 128'h66 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_bits: got %h, want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_saturation();
        drive(6'b000111, 1'b1, 128'h77, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL sat_cycle%0d: got %h, want %h", i, dut_vec(), model_vec());
            end
        end
        n_checks++;
        if (s_bubble !== 4'hF || bubble_cnt !== 16'd23) begin
            n_fail++;
            $display("FAIL sat_final: got narrow=%h wide=%0d, want f 23", s_bubble, bubble_cnt);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (s_bubble !== 4'h0 || bubble_cnt !== 16'd0 || s_hold !== 4'h0) begin
            n_fail++;
            $display("FAIL sat_reset: got narrow=%h wide=%0d hold=%h, want 0 0 0", s_bubble, bubble_cnt, s_hold);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(6'b0, 1'b1, 128'h88, 1'b1, 1'b1);
        tick();
        drive(6'b001111, 1'b1, 128'h99, 1'b1, 1'b1);
        flush = 1'b1;
        rst   = 1'b1;
        tick();
        n_checks++;
        if ({out_valid, out_delayslot, fb_in_delayslot, out_payload, bubble_cnt, hold_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got %h, want 0", dut_vec());
        end
        rst   = 1'b0;
        flush = 1'b0;
        drive(6'b0, 1'b1, 128'hAB, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({out_valid, fb_in_delayslot, out_payload} !== {2'b11, 128'hAB}) begin
            n_fail++;
            $display("FAIL first_advance_after_reset: got v=%b fb=%b pay=%h, want 1 1 ab",
                     out_valid, fb_in_delayslot, out_payload);
        end
    endtask

    task automatic test_random();
        logic [1:0] kind;
        logic       su, sd;
        for (int i = 0; i < 400; i++) begin
            kind = 2'($urandom_range(0, 3));
            su   = (kind == 2'd1) || (kind == 2'd2);
            sd   = (kind == 2'd2);
            drive({2'($urandom), sd, su, 2'($urandom)}, 1'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
            flush = ($urandom_range(0, 15) == 0);
            rst   = ($urandom_range(0, 63) == 0);
            tick();
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h, want %h", i, dut_vec(), model_vec());
            end
        end
        rst   = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        flush = 1'b0;
        drive(6'b0, 1'b0, '0, 1'b0, 1'b0);
        {m_valid, m_ds, m_fb, m_payload} = '0;
        m_bub  = 0;
        m_hold = 0;
        test_reset();
        test_advance();
        test_bubble();
        test_hold();
        test_flush();
        test_illegal_and_ignored();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
